// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down-counter sequencing controller.
// Consumers: down_counter_if, down_cnt_core, down_counter_ctrl.
package down_counter_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    HOLD = ST_HOLD,
    DONE = ST_DONE
  } ctrl_state_t;

  // Higher code wins when several commands arrive on the same edge.
  localparam logic [1:0] CMD_STEP  = 2'd0;
  localparam logic [1:0] CMD_PAUSE = 2'd1;
  localparam logic [1:0] CMD_START = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  function automatic logic [1:0] sel_cmd(input logic stop, input logic start, input logic pause);
    if (stop)  return CMD_STOP;
    if (start) return CMD_START;
    if (pause) return CMD_PAUSE;
    return CMD_STEP;
  endfunction

endpackage

// File: rtl/down_counter_if.sv
// Command/status bundle between the surrounding logic (master) and the
// down-counter controller (slave).
interface down_counter_if
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, stop, pause, auto_reload, reload_val,
    input  count, busy, tc, done
  );

  modport slave (
    input  start, stop, pause, auto_reload, reload_val,
    output count, busy, tc, done
  );
endinterface

// File: rtl/down_cnt_core.sv
// WIDTH-bit down-count register: load has priority over decrement, and the
// count floors at zero. zero_next flags the edge that will take count 1->0.
module down_cnt_core
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero_next
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - WIDTH'(1);
  end

  assign zero_next = dec && (count == WIDTH'(1));

endmodule

// File: rtl/down_counter_ctrl.sv
// Sequencing controller for the down counter: load, run, pause, stop, reload.
// Build option DOWN_COUNTER_PRESCALE_EN adds a PRESCALE-cycle step prescaler.
//
// state | meaning
// IDLE  | stopped, count 0, waiting for start
// RUN   | counting down (or waiting one step to auto-reload when count is 0)
// HOLD  | paused, count frozen
// DONE  | one-shot finished, count parked at 0
module down_counter_ctrl
  import down_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rst,
  down_counter_if.slave  bus
);

  logic [1:0]       state;
  logic [1:0]       nxt_state;
  logic [1:0]       cmd;
  logic             step;
  logic             load;
  logic             dec;
  logic             zero_next;
  logic             tc_q;
  logic             tc_nxt;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] count;

  if (PRESCALE < 1) begin : g_prescale_chk
    $error("down_counter_ctrl: PRESCALE must be >= 1");
  end

  assign cmd = sel_cmd(bus.stop, bus.start, bus.pause);

`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] psc;

  assign step = (psc == PW'(PRESCALE - 1));

  // Only free-runs while actually counting; any other command or state clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    psc <= '0;
    else if (state == ST_RUN && cmd == CMD_STEP) psc <= step ? '0 : psc + PW'(1);
    else                                         psc <= '0;
  end
`else
  assign step = 1'b1;
`endif

  assign dec = (cmd == CMD_STEP) && (state == ST_RUN) && step && (count != '0);

  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    ld_val    = bus.reload_val;
    tc_nxt    = 1'b0;
    case (cmd)
      CMD_STOP: begin
        nxt_state = ST_IDLE;
        load      = 1'b1;
        ld_val    = '0;
      end
      CMD_START: begin
        load = 1'b1;
        if (bus.reload_val == '0) begin
          nxt_state = ST_DONE;
          tc_nxt    = 1'b1;
        end else begin
          nxt_state = ST_RUN;
        end
      end
      CMD_PAUSE: begin
        if (state == ST_RUN) nxt_state = ST_HOLD;
      end
      default: begin
        if (state == ST_HOLD) begin
          nxt_state = ST_RUN;
        end else if (state == ST_RUN && step) begin
          // Count sitting at 0 in RUN means an auto-reload is due on this step.
          if (count == '0) begin
            load = 1'b1;
            if (bus.reload_val == '0) nxt_state = ST_DONE;
          end else if (zero_next) begin
            tc_nxt = 1'b1;
            if (!(bus.auto_reload && bus.reload_val != '0)) nxt_state = ST_DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      tc_q  <= 1'b0;
    end else begin
      state <= nxt_state;
      tc_q  <= tc_nxt;
    end
  end

  down_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (ld_val),
    .dec       (dec),
    .count     (count),
    .zero_next (zero_next)
  );

  assign bus.count = count;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state == ST_RUN) || (state == ST_HOLD);
  assign bus.done  = (state == ST_DONE);

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Scoreboard bench for down_counter_ctrl: a behavioural model predicts the
// outputs after every edge and a monitor compares them on the falling edge.
module tb_down_counter_ctrl;

  localparam int W   = 4;
  localparam int PSC = 4;
`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int STEP_P = PSC;
`else
  localparam int STEP_P = 1;
`endif

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  down_counter_if #(.WIDTH(W)) bus ();

  down_counter_ctrl #(.WIDTH(W), .PRESCALE(PSC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];

  // Reference model: plain counters and flags, one call per clock edge.
  int m_count = 0;
  int m_ph    = 0;
  bit m_run   = 0;
  bit m_hold  = 0;
  bit m_done  = 0;
  bit m_pend  = 0;
  bit m_tc    = 0;

  function automatic void model_step();
    int rv;
    rv   = int'(bus.reload_val);
    m_tc = 0;
    if (!rst || bus.stop) begin
      m_count = 0; m_ph = 0; m_run = 0; m_hold = 0; m_done = 0; m_pend = 0;
    end else if (bus.start) begin
      m_count = rv; m_ph = 0; m_pend = 0; m_hold = 0;
      if (rv == 0) begin m_run = 0; m_done = 1; m_tc = 1; end
      else begin m_run = 1; m_done = 0; end
    end else if (bus.pause) begin
      if (m_run && !m_hold) begin m_hold = 1; m_ph = 0; end
    end else if (m_hold) begin
      m_hold = 0;
    end else if (m_run) begin
      m_ph++;
      if (m_ph == STEP_P) begin
        m_ph = 0;
        if (m_pend) begin
          m_pend  = 0;
          m_count = rv;
          if (rv == 0) begin m_run = 0; m_done = 1; end
        end else begin
          m_count--;
          if (m_count == 0) begin
            m_tc = 1;
            if (bus.auto_reload && rv != 0) m_pend = 1;
            else begin m_run = 0; m_done = 1; end
          end
        end
      end
    end
  endfunction

  task automatic cycle();
    obs_t e;
    @(posedge clk);
    model_step();
    e.count = W'(m_count);
    e.busy  = m_run;
    e.tc    = m_tc;
    e.done  = m_done;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  task automatic run_until_count(input int v, input int budget);
    int n;
    n = 0;
    while (m_count != v && n < budget) begin
      cycle();
      n++;
    end
    total++;
    if (m_count != v) begin
      bad++;
      $display("FAIL wait_count got=%0d exp=%0d", m_count, v);
    end
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest prediction.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {bus.count, bus.busy, bus.tc, bus.done};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got count=%0d busy=%b tc=%b done=%b exp count=%0d busy=%b tc=%b done=%b",
                   $time, a.count, a.busy, a.tc, a.done, e.count, e.busy, e.tc, e.done);
        end
      end
    end
  end

  initial begin
    int lat;
    bit found;

    bus.start = 1'b1; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.auto_reload = 1'b0; bus.reload_val = W'(5);

    // Reset held 100 ns with start asserted, then first start after release.
    cycles(10);
    rst = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycles(25 + 5 * STEP_P);

    // Auto-reload, then drop to one-shot.
    bus.reload_val = W'(3); bus.auto_reload = 1'b1;
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    cycles(14 * STEP_P);
    bus.auto_reload = 1'b0;
    cycles(10 * STEP_P);

    // Pause at 6, stop at 4.
    bus.reload_val = W'(9);
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    run_until_count(6, 100);
    bus.pause = 1'b1; cycles(3); bus.pause = 1'b0;
    run_until_count(4, 100);
    bus.stop = 1'b1; cycle(); bus.stop = 1'b0;
    cycles(4);

    // Zero reload value.
    bus.reload_val = '0;
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    cycles(3);

    // start and stop together.
    bus.reload_val = W'(6);
    bus.start = 1'b1; bus.stop = 1'b1; cycle(); bus.start = 1'b0; bus.stop = 1'b0;
    cycles(3);

    // Restart at count 2.
    bus.reload_val = W'(5);
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    run_until_count(2, 100);
    bus.reload_val = W'(7);
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    cycles(3);

    // Asynchronous reset mid-count, checked before any clock edge.
    bus.reload_val = W'(9);
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    cycles(3);
    @(negedge clk); #1;
    rst = 1'b0; #1;
    check_int("async_rst", int'({bus.count, bus.busy, bus.tc, bus.done}), 0);
    cycles(3);
    rst = 1'b1;
    cycle();

    // Start-to-tc latency for reload value 2.
    bus.reload_val = W'(2); bus.auto_reload = 1'b0;
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    lat = -1; found = 0;
    for (int k = 1; k <= 200 && !found; k++) begin
      cycle();
      if (bus.tc) begin found = 1; lat = k; end
    end
    check_int("tc_latency", lat, 2 * STEP_P);
    cycles(3);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      bus.stop  = ($urandom_range(0, 39) == 0);
      bus.start = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0)  bus.pause = ~bus.pause;
      if ($urandom_range(0, 49) == 0) bus.auto_reload = ~bus.auto_reload;
      if ($urandom_range(0, 5) == 0)  bus.reload_val = W'($urandom_range(0, 15));
      cycle();
    end

    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    cycles(2);
    @(negedge clk); #1;
    check_int("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
